// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter: the broadcast packet, FU count and FIFO depth.
package cdb_arbiter_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ROB_IDX_LEN  = 5;
  localparam int unsigned NUM_FU       = 4;
  localparam int unsigned FU_BUF_DEPTH = 2;

  localparam int unsigned FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CNT_W    = $clog2(FU_BUF_DEPTH + 1);

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob_entry;
    logic [XLEN-1:0]        value;
    logic                   wrong_pred;
  } cdb_packet_t;

  function automatic logic [FU_IDX_W-1:0] rr_next(input logic [FU_IDX_W-1:0] idx);
    if (32'(idx) == NUM_FU - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports, squash and the CDB broadcast bundled as one interface.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU*ROB_IDX_LEN-1:0] fu_rob_entry;
  logic [NUM_FU*XLEN-1:0]        fu_value;
  logic [NUM_FU-1:0]             fu_wrong_pred;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          squash;
  logic                          complete_enable;
  logic [ROB_IDX_LEN-1:0]        complete_rob_entry;
  logic [XLEN-1:0]               value;
  logic                          wrong_pred;

  modport master (
    output fu_valid, fu_rob_entry, fu_value, fu_wrong_pred, squash,
    input  fu_ready, complete_enable, complete_rob_entry, value, wrong_pred
  );

  modport slave (
    input  fu_valid, fu_rob_entry, fu_value, fu_wrong_pred, squash,
    output fu_ready, complete_enable, complete_rob_entry, value, wrong_pred
  );

endinterface

// File: rtl/cdb_arbiter_fu_fifo.sv
// Single-FU circular result FIFO (power-of-two depth) with synchronous clear.
module cdb_arbiter_fu_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = FU_BUF_DEPTH,
  parameter int unsigned PtrW  = $clog2(Depth),
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  cdb_packet_t     wdata,
  output cdb_packet_t     rdata,
  output logic [CntW-1:0] count,
  output logic            empty,
  output logic            full
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  cdb_packet_t     mem [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_push = push && (count_q != DepthCnt);
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin serializer of per-FU results onto the single-wide CDB.
// Define CDB_BYPASS_EN to let an empty FU's incoming result win arbitration directly.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  cdb_packet_t         in_pkt   [NUM_FU];
  cdb_packet_t         head_pkt [NUM_FU];
  logic [CNT_W-1:0]    count    [NUM_FU];
  logic [NUM_FU-1:0]   push, pop, empty, full, cand;
  logic [FU_IDX_W-1:0] rr_q, winner;
  logic                found, bypass_win, en_q;
  cdb_packet_t         sel_pkt, out_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign in_pkt[i] = '{rob_entry:  bus.fu_rob_entry[i*ROB_IDX_LEN +: ROB_IDX_LEN],
                         value:      bus.fu_value[i*XLEN +: XLEN],
                         wrong_pred: bus.fu_wrong_pred[i]};
    assign bus.fu_ready[i] = (count[i] < CNT_W'(FU_BUF_DEPTH));
`ifdef CDB_BYPASS_EN
    assign cand[i] = ~empty[i] | bus.fu_valid[i];
`else
    assign cand[i] = ~empty[i];
`endif
    assign pop[i]  = found && (winner == FU_IDX_W'(i)) && ~empty[i] && ~bus.squash;
    // A bypassed winner is broadcast straight away and never enters its FIFO.
    assign push[i] = bus.fu_valid[i] && bus.fu_ready[i] && ~bus.squash &&
                     ~(bypass_win && (winner == FU_IDX_W'(i)));

    cdb_arbiter_fu_fifo u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .clear (bus.squash),
      .wdata (in_pkt[i]),
      .rdata (head_pkt[i]),
      .count (count[i]),
      .empty (empty[i]),
      .full  (full[i])
    );

    a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
      full[i] |-> !push[i]);
  end

  always_comb begin
    logic [FU_IDX_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = FU_IDX_W'((32'(rr_q) + k) % NUM_FU);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

`ifdef CDB_BYPASS_EN
  assign bypass_win = found && empty[winner];
`else
  assign bypass_win = 1'b0;
`endif

  assign sel_pkt = bypass_win ? in_pkt[winner] : head_pkt[winner];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q  <= '0;
      en_q  <= 1'b0;
      out_q <= '0;
    end else if (bus.squash) begin
      rr_q <= '0;
      en_q <= 1'b0;
    end else if (found) begin
      rr_q  <= rr_next(winner);
      en_q  <= 1'b1;
      out_q <= sel_pkt;
    end else begin
      en_q <= 1'b0;
    end
  end

  assign bus.complete_enable    = en_q;
  assign bus.complete_rob_entry = out_q.rob_entry;
  assign bus.value              = out_q.value;
  assign bus.wrong_pred         = out_q.wrong_pred;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a queue model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

`ifdef CDB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int NRows = 26;

  typedef struct packed {
    logic [3:0]  v;
    logic        sq;
    logic [19:0] tags;
    logic [31:0] vals;
    logic [3:0]  wp;
  } vin_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  tag;
    logic [31:0] val;
    logic        wp;
    logic [3:0]  rdy;
  } vexp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_bcast = 0;

  logic [NUM_FU-1:0] in_v;
  logic              in_sq;
  cdb_packet_t       in_p [NUM_FU];

  // Reference model: one queue per FU plus the broadcast register.
  cdb_packet_t mq [NUM_FU][$];
  int          m_rr;
  logic        m_en;
  cdb_packet_t m_out;
  logic [3:0]  m_rdy;

  vin_t  vin  [NRows];
  vexp_t vexp [NRows];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) mq[i].delete();
    m_rr  = 0;
    m_en  = 1'b0;
    m_out = '0;
    m_rdy = 4'hF;
  endtask

  task automatic model_step();
    logic [NUM_FU-1:0] rdy;
    bit found, byp;
    int w;
    for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[i].size() < FU_BUF_DEPTH);
    found = 0; byp = 0; w = 0;
    if (in_sq) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      m_en = 1'b0;
      m_rr = 0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        int i;
        i = (m_rr + k) % NUM_FU;
        if (!found && (mq[i].size() > 0 || (Byp && in_v[i]))) begin
          found = 1; w = i;
        end
      end
      if (found) begin
        if (mq[w].size() > 0) m_out = mq[w].pop_front();
        else begin m_out = in_p[w]; byp = 1; end
        m_en = 1'b1;
        m_rr = (w + 1) % NUM_FU;
      end else m_en = 1'b0;
      for (int i = 0; i < NUM_FU; i++)
        if (in_v[i] && rdy[i] && !(byp && i == w)) mq[i].push_back(in_p[i]);
    end
    for (int i = 0; i < NUM_FU; i++) m_rdy[i] = (mq[i].size() < FU_BUF_DEPTH);
  endtask

  task automatic drive();
    bus.fu_valid = in_v;
    bus.squash   = in_sq;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_rob_entry[i*ROB_IDX_LEN +: ROB_IDX_LEN] = in_p[i].rob_entry;
      bus.fu_value[i*XLEN +: XLEN]                   = in_p[i].value;
      bus.fu_wrong_pred[i]                           = in_p[i].wrong_pred;
    end
  endtask

  // One clock: drive, advance the model, sample #1 after the edge and compare everything.
  task automatic cycle();
    drive();
    model_step();
    @(posedge clock);
    #1;
    check("complete_enable", bus.complete_enable, m_en);
    check("complete_rob_entry", bus.complete_rob_entry, m_out.rob_entry);
    check("value", bus.value, m_out.value);
    check("wrong_pred", bus.wrong_pred, m_out.wrong_pred);
    check("fu_ready", bus.fu_ready, m_rdy);
    if (bus.complete_enable) n_bcast++;
  endtask

  task automatic idle_inputs();
    in_v  = '0;
    in_sq = 1'b0;
    for (int i = 0; i < NUM_FU; i++) in_p[i] = '0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_en"}, bus.complete_enable, 1'b0);
    check({tag, "_value"}, bus.value, 32'h0);
    check({tag, "_tag"}, bus.complete_rob_entry, 5'h0);
    check({tag, "_wp"}, bus.wrong_pred, 1'b0);
    check({tag, "_ready"}, bus.fu_ready, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vin = '{
      '{4'b0010, 1'b0, {5'd0, 5'd0, 5'd2, 5'd0}, {8'd0, 8'd0, 8'd1, 8'd0}, 4'b0000},
      '0, '0,
      '{4'b0000, 1'b1, 20'h0, 32'h0, 4'b0000},
      '{4'b0111, 1'b0, {5'd0, 5'd2, 5'd1, 5'd0}, {8'd0, 8'd12, 8'd11, 8'd10}, 4'b0000},
      '0, '0, '0, '0,
      '{4'b1001, 1'b0, {5'd3, 5'd0, 5'd0, 5'd4}, {8'd13, 8'd0, 8'd0, 8'd14}, 4'b0000},
      '0, '0,
      '{4'b0100, 1'b0, {5'd0, 5'd5, 5'd0, 5'd0}, {8'd0, 8'h40, 8'd0, 8'd0}, 4'b0100},
      '{4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd6}, {8'd0, 8'd0, 8'd0, 8'd7}, 4'b0000},
      '0, '0,
      '{4'b1111, 1'b0, {5'd11, 5'd10, 5'd9, 5'd8}, {8'd23, 8'd22, 8'd21, 8'd20}, 4'b0000},
      '{4'b1111, 1'b0, {5'd15, 5'd14, 5'd13, 5'd12}, {8'd27, 8'd26, 8'd25, 8'd24}, 4'b0000},
      '0, '0, '0, '0, '0, '0, '0, '0
    };
`ifdef CDB_BYPASS_EN
    vexp = '{
      '{1, 5'd2, 32'd1, 0, 4'hF}, '{0, 5'd2, 32'd1, 0, 4'hF}, '{0, 5'd2, 32'd1, 0, 4'hF},
      '{0, 5'd2, 32'd1, 0, 4'hF}, '{1, 5'd0, 32'd10, 0, 4'hF}, '{1, 5'd1, 32'd11, 0, 4'hF},
      '{1, 5'd2, 32'd12, 0, 4'hF}, '{0, 5'd2, 32'd12, 0, 4'hF}, '{0, 5'd2, 32'd12, 0, 4'hF},
      '{1, 5'd3, 32'd13, 0, 4'hF}, '{1, 5'd4, 32'd14, 0, 4'hF}, '{0, 5'd4, 32'd14, 0, 4'hF},
      '{1, 5'd5, 32'h40, 1, 4'hF}, '{1, 5'd6, 32'd7, 0, 4'hF}, '{0, 5'd6, 32'd7, 0, 4'hF},
      '{0, 5'd6, 32'd7, 0, 4'hF}, '{1, 5'd9, 32'd21, 0, 4'hF}, '{1, 5'd10, 32'd22, 0, 4'h6},
      '{1, 5'd11, 32'd23, 0, 4'hE}, '{1, 5'd8, 32'd20, 0, 4'hF}, '{1, 5'd13, 32'd25, 0, 4'hF},
      '{1, 5'd14, 32'd26, 0, 4'hF}, '{1, 5'd15, 32'd27, 0, 4'hF}, '{1, 5'd12, 32'd24, 0, 4'hF},
      '{0, 5'd12, 32'd24, 0, 4'hF}, '{0, 5'd12, 32'd24, 0, 4'hF}
    };
`else
    vexp = '{
      '{0, 5'd0, 32'd0, 0, 4'hF}, '{1, 5'd2, 32'd1, 0, 4'hF}, '{0, 5'd2, 32'd1, 0, 4'hF},
      '{0, 5'd2, 32'd1, 0, 4'hF}, '{0, 5'd2, 32'd1, 0, 4'hF}, '{1, 5'd0, 32'd10, 0, 4'hF},
      '{1, 5'd1, 32'd11, 0, 4'hF}, '{1, 5'd2, 32'd12, 0, 4'hF}, '{0, 5'd2, 32'd12, 0, 4'hF},
      '{0, 5'd2, 32'd12, 0, 4'hF}, '{1, 5'd3, 32'd13, 0, 4'hF}, '{1, 5'd4, 32'd14, 0, 4'hF},
      '{0, 5'd4, 32'd14, 0, 4'hF}, '{1, 5'd5, 32'h40, 1, 4'hF}, '{1, 5'd6, 32'd7, 0, 4'hF},
      '{0, 5'd6, 32'd7, 0, 4'hF}, '{0, 5'd6, 32'd7, 0, 4'hF}, '{1, 5'd9, 32'd21, 0, 4'h2},
      '{1, 5'd10, 32'd22, 0, 4'h6}, '{1, 5'd11, 32'd23, 0, 4'hE}, '{1, 5'd8, 32'd20, 0, 4'hF},
      '{1, 5'd13, 32'd25, 0, 4'hF}, '{1, 5'd14, 32'd26, 0, 4'hF}, '{1, 5'd15, 32'd27, 0, 4'hF},
      '{1, 5'd12, 32'd24, 0, 4'hF}, '{0, 5'd12, 32'd24, 0, 4'hF}
    };
`endif

    // Reset state
    idle_inputs();
    drive();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    reset = 1'b1;
    repeat (2) cycle();
    check("idle_after_reset_en", bus.complete_enable, 1'b0);

    // Directed vector table
    for (int r = 0; r < NRows; r++) begin
      in_v  = vin[r].v;
      in_sq = vin[r].sq;
      for (int i = 0; i < NUM_FU; i++)
        in_p[i] = '{rob_entry: vin[r].tags[i*5 +: 5], value: 32'(vin[r].vals[i*8 +: 8]),
                    wrong_pred: vin[r].wp[i]};
      cycle();
      check($sformatf("row%0d_en", r), bus.complete_enable, vexp[r].en);
      check($sformatf("row%0d_tag", r), bus.complete_rob_entry, vexp[r].tag);
      check($sformatf("row%0d_value", r), bus.value, vexp[r].val);
      check($sformatf("row%0d_wp", r), bus.wrong_pred, vexp[r].wp);
      check($sformatf("row%0d_ready", r), bus.fu_ready, vexp[r].rdy);
    end

    // Backpressure: every FU holds each result until accepted
    begin
      int   sent [NUM_FU];
      logic [NUM_FU-1:0] acc;
      bit   saw_full;
      saw_full = 0;
      n_bcast  = 0;
      for (int i = 0; i < NUM_FU; i++) sent[i] = 0;
      for (int c = 0; c < 30; c++) begin
        for (int i = 0; i < NUM_FU; i++) begin
          in_v[i] = (sent[i] < 4);
          in_p[i] = '{rob_entry: 5'(i * 4 + sent[i]), value: 32'(32'h100 * i + sent[i]),
                      wrong_pred: 1'b0};
        end
        acc = in_v & bus.fu_ready;
        if (bus.fu_ready != 4'hF) saw_full = 1;
        cycle();
        for (int i = 0; i < NUM_FU; i++) if (acc[i]) sent[i]++;
      end
      check("bp_broadcast_count", 64'(n_bcast), 64'd16);
      check("bp_ready_dropped", 64'(saw_full), 64'd1);
      check("bp_all_sent", 64'(sent[0] + sent[1] + sent[2] + sent[3]), 64'd16);
    end

    // Squash with three buffered results while FU3 presents a new one
    idle_inputs();
    in_v = 4'b0111;
    for (int i = 0; i < NUM_FU; i++) in_p[i] = '{rob_entry: 5'(20 + i), value: 32'(50 + i),
                                                 wrong_pred: 1'b0};
    cycle();
    in_v  = 4'b1000;
    in_sq = 1'b1;
    cycle();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      check("squash_ready", bus.fu_ready, 4'hF);
      cycle();
      check("squash_no_bcast", bus.complete_enable, 1'b0);
    end

    // Asynchronous reset in the middle of traffic
    in_v = 4'hF;
    for (int i = 0; i < NUM_FU; i++) in_p[i] = '{rob_entry: 5'($urandom), value: $urandom,
                                                 wrong_pred: 1'($urandom)};
    cycle();
    cycle();
    #3 reset = 1'b0;
    #1;
    check_cleared("midreset");
    model_reset();
    #2 reset = 1'b1;
    idle_inputs();
    cycle();
    check("midreset_no_bcast", bus.complete_enable, 1'b0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      in_v  = 4'($urandom);
      in_sq = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < NUM_FU; i++) in_p[i] = '{rob_entry: 5'($urandom), value: $urandom,
                                                   wrong_pred: 1'($urandom)};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects finished results from the functional units and serializes them onto the single-wide common data bus (CDB).
- The CDB drives the ROB completion inputs: complete_enable, complete_rob_entry, value and wrong_pred.
- Sits between the FU/execute stage and the rob.
- Buffers each FU's results in a small per-FU FIFO and grants one FU per cycle using round-robin arbitration.

Parameters:
NUM_FU, 4, number of functional-unit result ports
FU_BUF_DEPTH, 2, entries per per-FU result FIFO (power of two, >=2)
XLEN, `XLEN (32), data width
ROB_IDX_LEN, `ROB_IDX_LEN, ROB tag width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fu_valid  in  NUM_FU  FU i presents a result this cycle
fu_rob_entry  in  NUM_FU*ROB_IDX_LEN  ROB tag per FU
fu_value  in  NUM_FU*XLEN  result value per FU
fu_wrong_pred  in  NUM_FU  branch mispredict flag per FU
fu_ready  out  NUM_FU  FU i's FIFO can accept a result
squash  in  1  flush all buffered results (mispredict at ROB head)
complete_enable  out  1  CDB broadcast valid
complete_rob_entry  out  ROB_IDX_LEN  broadcast ROB tag
value  out  XLEN  broadcast value
wrong_pred  out  1  broadcast mispredict flag

Behaviour:
- Reset (reset==0, async): all FIFOs empty; RR pointer=0; complete_enable=0; complete_rob_entry=0; value=0; wrong_pred=0; fu_ready=all 1.
- fu_ready[i] = FIFO i count < FU_BUF_DEPTH. It is combinational from registered count only; a pop in the same cycle does not raise it.
- Enqueue: at a rising edge, FIFO i captures its packet when fu_valid[i] && fu_ready[i]. fu_valid while !fu_ready is dropped, so the FU must hold its result.
- Arbitration (combinational, each cycle):
  - Candidates are the non-empty FIFO heads.
  - Search starts at the RR pointer and wraps modulo NUM_FU.
  - The first candidate wins.
- At the rising edge:
  - The winner is popped and latched into the registered output stage; complete_enable=1.
  - The RR pointer becomes winner+1 (mod NUM_FU).
  - With no candidate: complete_enable=0, the data outputs hold their last value, and the pointer is unchanged.
- Outputs are valid for exactly one cycle per result. Results from the same FU broadcast in FIFO order.
- Latency (feature off): enqueue edge E0 -> broadcast visible after E1 at minimum.
- Throughput: one broadcast per cycle. Per-FU FIFO push and pop in the same edge are allowed.
- Squash (synchronous, highest priority):
  - At the edge where squash==1, all FIFOs are cleared, including same-cycle fu_valid inputs.
  - complete_enable=0 next cycle and the RR pointer=0.
  - fu_ready returns to all 1 in the following cycle.
- Wrap-around: FIFO read/write pointers are log2(FU_BUF_DEPTH) bits with a separate count; counts saturate logically at FU_BUF_DEPTH.
- Reset asserted mid-operation: immediate clear, with no partial broadcast.

Optional Feature:
CDB_BYPASS_EN:
- Defined:
  - A FU whose FIFO is empty and has fu_valid set is an arbitration candidate using its incoming packet.
  - If it wins, the packet goes straight to the output register and is not enqueued, giving 1-edge latency.
  - If it loses, it is enqueued normally.
  - Squash still drops it.
- Undefined: all results pass through the FIFO; minimum latency is 2 edges.

Decomposition:
- Shared package (sys_defs): typedef CDB_PACKET {rob_entry [ROB_IDX_LEN], value [XLEN], wrong_pred}; constants NUM_FU and FU_BUF_DEPTH.
- One sub-module, cdb_fu_fifo: a single-FU circular FIFO of CDB_PACKET with push, pop, clear, count, empty and full. It is instantiated NUM_FU times.
- Round-robin arbitration and the output register stay in cdb_arbiter.

Test Plan:
1. Reset: hold reset=0 for 2 cycles -> complete_enable=0, value=0, fu_ready=4'b1111; release with no fu_valid -> complete_enable stays 0.
2. Single result, feature off: FU1 rob_entry=2, value=1 at E0 -> after E1: complete_enable=1, complete_rob_entry=2, value=1; after E2: complete_enable=0. With CDB_BYPASS_EN the same broadcast appears after E0.
3. Contention: FU0, FU1 and FU2 valid in the same cycle with tags 0/1/2 and values 10/11/12, pointer=0 -> three consecutive broadcasts of tags 0, 1, 2; pointer ends at 3.
4. Backpressure: all 4 FUs hold valid for 4 cycles, re-presenting until fu_ready -> fu_ready bits drop to 0 when FIFOs fill. Exactly 16 distinct broadcasts result, none lost or duplicated, with per-FU order preserved.
5. Squash: 3 results buffered, assert squash for 1 cycle while FU3 is also valid -> complete_enable=0 on the next cycle and onward; nothing from the pre-squash results is broadcast; fu_ready=4'b1111.
6. Mispredict pass-through: FU2 rob_entry=5, value=32'h40, fu_wrong_pred=1 -> broadcast with complete_entry=5, wrong_pred=1; the next FU0 result broadcasts with wrong_pred=0.
